// File: rtl/vmode_line_prefetch_if.sv
// VRAM read port between the scanline prefetcher (master) and the VRAM bus arbiter (slave).
// Handshake: the master raises bus_request with a stable, word-aligned bus_address and holds both
// until the slave pulses bus_ready for one cycle with bus_rdata valid; that cycle completes the read.
interface vmode_line_prefetch_if;
    logic        bus_request;
    logic [31:0] bus_address;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_request,
        output bus_address,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_request,
        input  bus_address,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/vmode_line_prefetch.sv
// Scanline prefetcher: fetches one line of 8-bit palette indices from VRAM into a ping-pong
// line buffer (line y lives in bank y[0]) and serves single pixels to the video side.
module vmode_line_prefetch #(
    parameter int          PPITCH = 320,
    parameter int          LINES  = 200,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_prefetch,
    input  logic [9:0]            i_prefetch_y,
    output logic                  o_busy,
    vmode_line_prefetch_if.master bus,
    input  logic                  i_video_request,
    input  logic [9:0]            i_video_pos_x,
    input  logic [9:0]            i_video_pos_y,
    output logic [7:0]            o_video_rdata,
    output logic                  o_underrun,
    input  logic                  i_clear_underrun,
    output logic [1:0]            o_debug_state
);
    localparam int            WORDS     = PPITCH / 4;
    localparam int            WW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_NEXT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [9:0]    line_y;
    logic [WW-1:0] word;
    logic [1:0]    bank_valid;
    logic [9:0]    bank_tag [2];
    logic [31:0]   bank_mem [2][WORDS];

    logic          start;
    logic [31:0]   fetch_address;

    // Out-of-range lines are dropped here so the FSM never sees them.
    assign start         = i_prefetch && ({22'd0, i_prefetch_y} < LINES[31:0]);
    assign fetch_address = BASE + ({22'd0, line_y} * PPITCH[31:0]) + ({{(32-WW){1'b0}}, word} << 2);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_REQ;
            S_REQ:   if (bus.bus_ready) state_next = S_NEXT;
            S_NEXT:  state_next = (word == LAST_WORD) ? S_IDLE : S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.bus_request = 1'b0;
        bus.bus_address = 32'h0;
        o_busy          = (state != S_IDLE);
        o_debug_state   = state;
        if (state == S_REQ) begin
            bus.bus_request = 1'b1;
            bus.bus_address = fetch_address;
        end
    end

    // The target bank is invalidated at fetch start so a half-filled line can never be displayed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            line_y      <= '0;
            word        <= '0;
            bank_valid  <= '0;
            bank_tag[0] <= '0;
            bank_tag[1] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        line_y                       <= i_prefetch_y;
                        word                         <= '0;
                        bank_valid[i_prefetch_y[0]]  <= 1'b0;
                        bank_tag[i_prefetch_y[0]]    <= i_prefetch_y;
                    end
                end
                S_NEXT: begin
                    if (word == LAST_WORD) begin
                        bank_valid[line_y[0]] <= 1'b1;
                    end else begin
                        word <= word + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && state == S_REQ && bus.bus_ready) begin
            bank_mem[line_y[0]][word] <= bus.bus_rdata;
        end
    end

    logic          rd_bank;
    logic          line_hit;
    logic          x_in;
    logic [WW-1:0] rd_word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;

    assign rd_bank     = i_video_pos_y[0];
    assign line_hit    = bank_valid[rd_bank] && (bank_tag[rd_bank] == i_video_pos_y);
    assign x_in        = {22'd0, i_video_pos_x} < PPITCH[31:0];
    assign rd_word_idx = i_video_pos_x[WW+1:2];
    assign rd_word     = bank_mem[rd_bank][rd_word_idx];
    assign rd_byte     = rd_word[{i_video_pos_x[1:0], 3'b000} +: 8];

    // A column past the line end reads 0 but is not a residency miss, so it leaves o_underrun alone.
    // A new miss is written after the clear so it wins in the same cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_video_rdata <= 8'h00;
            o_underrun    <= 1'b0;
        end else begin
            if (i_clear_underrun) begin
                o_underrun <= 1'b0;
            end
            if (i_video_request) begin
                o_video_rdata <= (line_hit && x_in) ? rd_byte : 8'h00;
                if (!line_hit) begin
                    o_underrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vmode_line_prefetch.sv
// Randomized scoreboard bench for vmode_line_prefetch: a small 8-pixel line instance with a variable
// latency VRAM model, plus a full 320-pixel instance on a zero-wait bus for fetch timing.
module tb_vmode_line_prefetch;
    localparam int          PPITCH_A = 8;
    localparam int          LINES_A  = 200;
    localparam logic [31:0] BASE_A   = 32'h100;
    localparam int          PPITCH_B = 320;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       pf_a;
    logic [9:0] pf_y_a;
    logic       busy_a;
    logic       vreq;
    logic [9:0] vx;
    logic [9:0] vy;
    logic [7:0] rdata_a;
    logic       underrun_a;
    logic       clr_a;
    logic [1:0] dbg_a;

    logic       pf_b;
    logic [9:0] pf_y_b;
    logic       busy_b;
    logic       vreq_b;
    logic [9:0] vx_b;
    logic [9:0] vy_b;
    logic [7:0] rdata_b;
    logic       underrun_b;
    logic       clr_b;
    logic [1:0] dbg_b;

    vmode_line_prefetch_if bus_a ();
    vmode_line_prefetch_if bus_b ();

    vmode_line_prefetch #(.PPITCH(PPITCH_A), .LINES(LINES_A), .BASE(BASE_A)) dut_a (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_prefetch       (pf_a),
        .i_prefetch_y     (pf_y_a),
        .o_busy           (busy_a),
        .bus              (bus_a),
        .i_video_request  (vreq),
        .i_video_pos_x    (vx),
        .i_video_pos_y    (vy),
        .o_video_rdata    (rdata_a),
        .o_underrun       (underrun_a),
        .i_clear_underrun (clr_a),
        .o_debug_state    (dbg_a)
    );

    vmode_line_prefetch #(.PPITCH(PPITCH_B), .LINES(200), .BASE(32'h0)) dut_b (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_prefetch       (pf_b),
        .i_prefetch_y     (pf_y_b),
        .o_busy           (busy_b),
        .bus              (bus_b),
        .i_video_request  (vreq_b),
        .i_video_pos_x    (vx_b),
        .i_video_pos_y    (vy_b),
        .o_video_rdata    (rdata_b),
        .o_underrun       (underrun_b),
        .i_clear_underrun (clr_b),
        .o_debug_state    (dbg_b)
    );

    // Zero-wait bus for the full-size instance: every request completes in its first cycle.
    assign bus_b.bus_ready = bus_b.bus_request;
    assign bus_b.bus_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] vram[logic [31:0]];

    bit         m_valid[2];
    logic [9:0] m_tag[2];
    bit         m_busy;
    logic [9:0] m_fy;
    bit         m_ur;

    int   fixed_lat     = 0;
    bit   rsp_en        = 1'b1;
    logic manual_ready  = 1'b0;
    logic vreq_d        = 1'b0;
    int   b_reqs        = 0;
    logic [31:0] b_last = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] vram_word(input logic [31:0] a);
        if (!vram.exists(a)) vram[a] = $urandom;
        return vram[a];
    endfunction

    function automatic logic [7:0] pixel(input int x, input int y);
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] sh;
        a  = BASE_A + 32'(y * PPITCH_A + (x / 4) * 4);
        w  = vram.exists(a) ? vram[a] : 32'h0;
        sh = w >> (8 * (x % 4));
        return sh[7:0];
    endfunction

    task automatic prefetch_a(input int y);
        if (y < LINES_A && !m_busy) begin
            m_valid[y % 2] = 1'b0;
            m_tag[y % 2]   = 10'(y);
            m_busy         = 1'b1;
            m_fy           = 10'(y);
            for (int k = 0; k < PPITCH_A / 4; k++) begin
                addr_q.push_back(BASE_A + 32'(y * PPITCH_A + 4 * k));
            end
        end
        pf_a   = 1'b1;
        pf_y_a = 10'(y);
        tick();
        pf_a   = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 1000) begin
            tick();
            n++;
        end
        check("fetch_done", {31'd0, busy_a}, 32'd0);
        check("fetch_all_words_requested", addr_q.size(), 32'd0);
        if (m_busy) begin
            m_valid[m_fy[0]] = 1'b1;
            m_busy           = 1'b0;
        end
    endtask

    task automatic video_read(input int x, input int y, input bit with_clear);
        bit         line_ok;
        logic [7:0] b;
        line_ok = m_valid[y % 2] && (m_tag[y % 2] == 10'(y));
        b       = (line_ok && x < PPITCH_A) ? pixel(x, y) : 8'h00;
        if (with_clear) m_ur = 1'b0;
        if (!line_ok) m_ur = 1'b1;
        exp_q.push_back({m_ur, b});
        vreq  = 1'b1;
        vx    = 10'(x);
        vy    = 10'(y);
        clr_a = with_clear;
        tick();
        vreq  = 1'b0;
        clr_a = 1'b0;
    endtask

    task automatic clear_ur();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        m_ur  = 1'b0;
        check("underrun_cleared", {31'd0, underrun_a}, 32'd0);
    endtask

    // VRAM responder for the small instance: random or fixed latency, data from the VRAM model.
    initial begin
        int wait_cnt = 0;
        int lat      = 1;
        bus_a.bus_ready = 1'b0;
        bus_a.bus_rdata = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            bus_a.bus_ready = 1'b0;
            if (!rsp_en) begin
                bus_a.bus_ready = manual_ready;
                bus_a.bus_rdata = $urandom;
            end else if (bus_a.bus_request === 1'b1) begin
                if (wait_cnt == 0) lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    bus_a.bus_ready = 1'b1;
                    bus_a.bus_rdata = vram_word(bus_a.bus_address);
                    wait_cnt        = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(posedge clock) vreq_d <= vreq;

    always @(negedge clock) begin
        if (vreq_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL video_unexpected: got rdata %0h with no read outstanding", rdata_a);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("video_rdata", {24'd0, rdata_a}, {24'd0, e[7:0]});
                check("video_underrun", {31'd0, underrun_a}, {31'd0, e[8]});
            end
        end
    end

    always @(negedge clock) begin
        if (bus_a.bus_request === 1'b1 && bus_a.bus_ready === 1'b1) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_extra_request: got address %0h, expected no request", bus_a.bus_address);
            end else begin
                check("bus_address", bus_a.bus_address, addr_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (bus_b.bus_request === 1'b1 && bus_b.bus_ready === 1'b1) begin
            b_reqs <= b_reqs + 1;
            b_last <= bus_b.bus_address;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int b_start;
        reset  = 1'b1;
        pf_a   = 1'b0;
        pf_y_a = '0;
        vreq   = 1'b0;
        vx     = '0;
        vy     = '0;
        clr_a  = 1'b0;
        pf_b   = 1'b0;
        pf_y_b = '0;
        vreq_b = 1'b0;
        vx_b   = '0;
        vy_b   = '0;
        clr_b  = 1'b0;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_tag[0]   = '0;
        m_tag[1]   = '0;
        m_busy     = 1'b0;
        m_fy       = '0;
        m_ur       = 1'b0;

        repeat (3) tick();
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_request", {31'd0, bus_a.bus_request}, 32'd0);
        check("reset_address", bus_a.bus_address, 32'd0);
        check("reset_rdata", {24'd0, rdata_a}, 32'd0);
        check("reset_underrun", {31'd0, underrun_a}, 32'd0);
        reset = 1'b0;
        tick();

        // Line 3 with ready two cycles into each request, then read it back in full.
        fixed_lat = 2;
        prefetch_a(3);
        wait_idle_a();
        for (int x = 0; x < PPITCH_A; x++) video_read(x, 3, 1'b0);

        // Full-size line on a zero-wait bus.
        b_start = b_reqs;
        pf_b    = 1'b1;
        pf_y_b  = 10'd0;
        tick();
        pf_b = 1'b0;
        n    = 1;
        while (busy_b && n < 1000) begin
            tick();
            n++;
        end
        check("b_busy_cycles", 32'(n), 32'd161);
        check("b_request_count", 32'(b_reqs - b_start), 32'd80);
        check("b_last_address", b_last, 32'd316);

        // Fetch line 4 while line 3 is displayed from the other bank.
        fixed_lat = 0;
        prefetch_a(4);
        video_read($urandom_range(0, PPITCH_A - 1), 3, 1'b0);
        video_read($urandom_range(0, PPITCH_A - 1), 3, 1'b0);
        check("underrun_before_miss", {31'd0, underrun_a}, 32'd0);
        video_read(0, 4, 1'b0);
        n = 0;
        while (busy_a && n < 200) begin
            video_read($urandom_range(0, PPITCH_A - 1), 3, 1'b0);
            n++;
        end
        wait_idle_a();
        check("underrun_sticky", {31'd0, underrun_a}, 32'd1);
        clear_ur();
        video_read(0, 9, 1'b1);
        tick();
        check("underrun_set_beats_clear", {31'd0, underrun_a}, 32'd1);
        clear_ur();
        for (int i = 0; i < 6; i++) video_read($urandom_range(0, PPITCH_A - 1), 4, 1'b0);

        // A second pulse while busy and an out-of-range line must both be ignored.
        prefetch_a(5);
        prefetch_a(6);
        wait_idle_a();
        prefetch_a(200);
        repeat (3) tick();
        check("y200_ignored", {31'd0, busy_a}, 32'd0);
        for (int i = 0; i < 6; i++) video_read($urandom_range(0, PPITCH_A - 1), 4 + (i % 2), 1'b0);

        // Columns past the line end read 0 without flagging underrun.
        video_read(8, 5, 1'b0);
        video_read(320, 5, 1'b0);
        video_read(1023, 4, 1'b0);
        tick();
        check("x_oob_no_underrun", {31'd0, underrun_a}, 32'd0);

        // Reset while a request is waiting for ready; a late ready afterwards must be ignored.
        rsp_en       = 1'b0;
        manual_ready = 1'b0;
        prefetch_a(7);
        repeat (2) tick();
        check("req_pending", {31'd0, bus_a.bus_request}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addr_q.delete();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_busy     = 1'b0;
        m_ur       = 1'b0;
        check("req_dropped", {31'd0, bus_a.bus_request}, 32'd0);
        check("busy_dropped", {31'd0, busy_a}, 32'd0);
        manual_ready = 1'b1;
        repeat (2) tick();
        manual_ready = 1'b0;
        repeat (2) tick();
        check("late_ready_no_request", {31'd0, bus_a.bus_request}, 32'd0);
        check("late_ready_idle", {31'd0, busy_a}, 32'd0);
        rsp_en = 1'b1;
        video_read(0, 7, 1'b0);
        video_read(0, 5, 1'b0);
        video_read(3, 4, 1'b0);

        repeat (3) tick();
        check("video_queue_drained", exp_q.size(), 32'd0);
        check("address_queue_drained", addr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
